mask_pixel_counter: RTL and testbench
=====================================

MASK_PIXEL_COUNTER -- requirements
Module: mask_pixel_counter

Interface
REQ-001 Parameter THRESH, default 8'd128: luma threshold; pixel is foreground when pix_luma >= THRESH.
REQ-002 Parameter MIN_RUN, default 8'd4: minimum horizontal run length (pixels) counted as one segment.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tv_x  input  10  current pixel column.
REQ-006 tv_y  input  10  current pixel row (informational; not used for decisions).
REQ-007 pix_valid  input  1  pixel qualifier; pixel inputs sampled only when high.
REQ-008 pix_luma  input  8  pixel luminance.
REQ-009 mask  input  11  region mask from the mask stage; pixel is in-region when mask != 0.
REQ-010 en  input  1  counting enable; when low no pixel is foreground.
REQ-011 sof  input  1  one-cycle start-of-frame pulse.
REQ-012 eof  input  1  one-cycle end-of-frame pulse.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_valid  output  1  result registers hold an unconsumed frame result.
REQ-015 res_pix_count  output  20  foreground in-region pixel count of last completed frame.
REQ-016 res_run_count  output  16  qualifying run count of last completed frame.
REQ-017 dropped  output  8  saturating count of results overwritten before acceptance.

Function
REQ-018 Foreground (fg) SHALL be pix_valid && en && (mask != 0) && (pix_luma >= THRESH).
REQ-019 FSM SHALL have two states: WAIT_SOF (accumulators idle, pixels ignored) and ACCUM; reset state WAIT_SOF.
REQ-020 WAIT_SOF -> ACCUM on sof; ACCUM -> WAIT_SOF on eof; sof while in ACCUM SHALL clear accumulators and stay in ACCUM (aborted frame, no result).
REQ-021 A pixel presented in the same cycle as sof SHALL be the first pixel of the new frame.
REQ-022 In ACCUM, each fg pixel SHALL increment pix_acc (20 bits, saturating at 20'hFFFFF).
REQ-023 run_len (8 bits, saturating at 255) SHALL increment on each fg pixel and reset to 0 when a run terminates.
REQ-024 A run SHALL terminate on a pix_valid non-fg pixel, on a pix_valid pixel with tv_x == 0 (new line; that pixel then starts a fresh run if fg), or on eof.
REQ-025 On termination, run_acc (16 bits, saturating at 16'hFFFF) SHALL increment iff run_len >= MIN_RUN.
REQ-026 On eof in ACCUM, result SHALL include the pixel and run terminated in that same cycle; res_pix_count/res_run_count load the final values and res_valid rises on the next cycle (latency 1); accumulators clear.
REQ-027 eof in WAIT_SOF SHALL be ignored (no result, no state change).
REQ-028 sof and eof in the same cycle in ACCUM: eof completes the frame (REQ-026), then accumulation restarts in ACCUM with cleared accumulators.
REQ-029 res_valid SHALL clear on the cycle after res_valid && res_ready, unless a new result loads in that cycle, in which case res_valid stays high.
REQ-030 New result loading while res_valid high and res_ready low SHALL overwrite result registers and increment dropped (saturating at 255).
REQ-031 Result outputs SHALL be stable while res_valid high and no new result loads.

Reset
REQ-032 reset_n low SHALL asynchronously force: state WAIT_SOF, pix_acc/run_acc/run_len 0, res_valid 0, res_pix_count 0, res_run_count 0, dropped 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, no pixel counts until next sof.

Verification
REQ-034 sof; one line tv_x 0..9 fg at x=2..7 (6 px), others luma 0; eof -> next cycle res_valid=1, res_pix_count=6, res_run_count=1.
REQ-035 Runs of 3 and 4 fg px separated by one non-fg px, MIN_RUN=4 -> res_pix_count=7, res_run_count=1; fg run crossing tv_x wrap to 0 (3+3 px) -> run_count=0.
REQ-036 fg luma with mask=0 or en=0 for 100 px -> res_pix_count=0; luma=THRESH-1 -> not counted, luma=THRESH -> counted.
REQ-037 Two frames, res_ready held low -> second eof overwrites, dropped=1, res_valid stays 1; then res_ready=1 one cycle -> res_valid=0 next cycle.
REQ-038 Assert reset_n low mid-frame after 50 fg px, release, then eof without sof -> res_valid stays 0; sof, 5 fg px (MIN_RUN=4), eof -> res_pix_count=5, res_run_count=1.

Source files
------------

// File: rtl/mask_pixel_counter.sv
// Counts foreground in-region pixels and qualifying horizontal runs for each frame.
// Latency: the result registers load on the eof cycle, so res_valid is high one cycle after eof.
// Backpressure: a result that is not accepted is overwritten by the next one, and dropped counts each overwrite.
module mask_pixel_counter #(
  parameter logic [7:0] THRESH  = 8'd128,
  parameter logic [7:0] MIN_RUN = 8'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  tv_x,
  input  logic [9:0]  tv_y,
  input  logic        pix_valid,
  input  logic [7:0]  pix_luma,
  input  logic [10:0] mask,
  input  logic        en,
  input  logic        sof,
  input  logic        eof,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [19:0] res_pix_count,
  output logic [15:0] res_run_count,
  output logic [7:0]  dropped
);

  typedef enum logic {WAIT_SOF = 1'b0, ACCUM = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [19:0] pix_acc_q, pix_acc_d;
  logic [15:0] run_acc_q, run_acc_d;
  logic [7:0]  run_len_q, run_len_d;
  logic        res_valid_q, res_valid_d;
  logic [19:0] res_pix_q, res_pix_d;
  logic [15:0] res_run_q, res_run_d;
  logic [7:0]  dropped_q, dropped_d;

  logic        fg, new_line, complete, fresh, load;
  logic        old_term, eof_term;
  logic [19:0] pix_base, pix_next;
  logic [15:0] run_base, run_next;
  logic [16:0] run_sum;
  logic [7:0]  len_base, len_next;

  // Row number is carried for context only; no decision depends on it.
  logic unused_tv_y;
  assign unused_tv_y = ^tv_y;

  // Per-pixel classification and next-value arithmetic for the accumulators.
  always_comb begin
    fg       = pix_valid && en && (mask != 11'd0) && (pix_luma >= THRESH);
    new_line = pix_valid && (tv_x == 10'd0);
    complete = (state_q == ACCUM) && eof;
    // sof without a completing eof restarts from zero; the sof-cycle pixel joins the new frame.
    fresh    = sof && !complete;
    pix_base = fresh ? 20'd0 : pix_acc_q;
    run_base = fresh ? 16'd0 : run_acc_q;
    len_base = fresh ? 8'd0  : run_len_q;

    pix_next = (fg && (pix_base != 20'hFFFFF)) ? pix_base + 20'd1 : pix_base;

    // The run in progress ends on a visible non-fg pixel or at the start of a new line.
    // A zero-length run is not a run, even if MIN_RUN is 0.
    old_term = pix_valid && (!fg || new_line) && (len_base != 8'd0) && (len_base >= MIN_RUN);

    len_next = len_base;
    if (fg) begin
      if (new_line)               len_next = 8'd1;
      else if (len_base != 8'hFF) len_next = len_base + 8'd1;
    end else if (pix_valid) begin
      len_next = 8'd0;
    end

    // eof also ends whatever run is open after this cycle's pixel.
    eof_term = complete && (len_next != 8'd0) && (len_next >= MIN_RUN);
    run_sum  = {1'b0, run_base} + {16'd0, old_term} + {16'd0, eof_term};
    run_next = run_sum[16] ? 16'hFFFF : run_sum[15:0];
  end

  // Frame FSM: decides when the accumulators advance, clear, or hand off a result.
  always_comb begin
    state_d   = state_q;
    pix_acc_d = pix_acc_q;
    run_acc_d = run_acc_q;
    run_len_d = run_len_q;
    load      = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          state_d   = ACCUM;
          pix_acc_d = pix_next;
          run_acc_d = run_next;
          run_len_d = len_next;
        end
      end
      ACCUM: begin
        if (eof) begin
          // A coincident sof reopens the frame with empty accumulators.
          load      = 1'b1;
          state_d   = sof ? ACCUM : WAIT_SOF;
          pix_acc_d = 20'd0;
          run_acc_d = 16'd0;
          run_len_d = 8'd0;
        end else begin
          pix_acc_d = pix_next;
          run_acc_d = run_next;
          run_len_d = len_next;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // Result handshake: load on frame completion, clear on acceptance, count overwrites.
  always_comb begin
    res_valid_d = res_valid_q;
    res_pix_d   = res_pix_q;
    res_run_d   = res_run_q;
    dropped_d   = dropped_q;
    if (load) begin
      res_valid_d = 1'b1;
      res_pix_d   = pix_next;
      res_run_d   = run_next;
      if (res_valid_q && !res_ready && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_SOF;
      pix_acc_q   <= 20'd0;
      run_acc_q   <= 16'd0;
      run_len_q   <= 8'd0;
      res_valid_q <= 1'b0;
      res_pix_q   <= 20'd0;
      res_run_q   <= 16'd0;
      dropped_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      pix_acc_q   <= pix_acc_d;
      run_acc_q   <= run_acc_d;
      run_len_q   <= run_len_d;
      res_valid_q <= res_valid_d;
      res_pix_q   <= res_pix_d;
      res_run_q   <= res_run_d;
      dropped_q   <= dropped_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_pix_count = res_pix_q;
  assign res_run_count = res_run_q;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_mask_pixel_counter.sv
// Directed bench for mask_pixel_counter with default THRESH=128, MIN_RUN=4.
// Frame-shaped vectors come from a table; reset, overwrite and sof/eof corners are hand sequences.
// Inputs change 1ns after the rising edge and outputs are sampled at the same point.
module tb_mask_pixel_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  tv_x;
  logic [9:0]  tv_y;
  logic        pix_valid;
  logic [7:0]  pix_luma;
  logic [10:0] mask;
  logic        en;
  logic        sof;
  logic        eof;
  logic        res_ready;
  logic        res_valid;
  logic [19:0] res_pix_count;
  logic [15:0] res_run_count;
  logic [7:0]  dropped;

  int n_cmp = 0;
  int n_err = 0;

  mask_pixel_counter dut (
    .clk(clk), .reset_n(reset_n), .tv_x(tv_x), .tv_y(tv_y),
    .pix_valid(pix_valid), .pix_luma(pix_luma), .mask(mask), .en(en),
    .sof(sof), .eof(eof), .res_ready(res_ready), .res_valid(res_valid),
    .res_pix_count(res_pix_count), .res_run_count(res_run_count), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*12-1:0] name;
    int              width;
    int              nlines;
    logic [15:0]     pat0;   // fg columns of the first line
    logic [15:0]     pat1;   // fg columns of every later line
    logic [7:0]      luma;   // luma of the pattern pixels; others are 0
    logic [10:0]     mask;
    logic            en;
    int              exp_pix;
    int              exp_run;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given pixel/strobe values, then back to idle.
  task automatic px(input logic v, input int x, input logic [7:0] l, input logic s, input logic e);
    pix_valid = v;
    tv_x      = x[9:0];
    pix_luma  = l;
    sof       = s;
    eof       = e;
    step();
    pix_valid = 1'b0;
    tv_x      = 10'd0;
    pix_luma  = 8'd0;
    sof       = 1'b0;
    eof       = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"six_px",    10,  1, 16'h00FC, 16'h0000, 8'd200, 11'h001, 1'b1,  6, 1};
    vecs[1] = '{"run3_run4", 10,  1, 16'h00F7, 16'h0000, 8'd200, 11'h001, 1'b1,  7, 1};
    vecs[2] = '{"wrap3_3",   10,  2, 16'h0380, 16'h0007, 8'd200, 11'h001, 1'b1,  6, 0};
    vecs[3] = '{"mask_zero", 10, 10, 16'h03FF, 16'h03FF, 8'd255, 11'h000, 1'b1,  0, 0};
    vecs[4] = '{"en_low",    10, 10, 16'h03FF, 16'h03FF, 8'd255, 11'h7FF, 1'b0,  0, 0};
    vecs[5] = '{"luma_127",  10,  1, 16'h03FF, 16'h0000, 8'd127, 11'h001, 1'b1,  0, 0};
    vecs[6] = '{"luma_128",  10,  2, 16'h03FF, 16'h03FF, 8'd128, 11'h001, 1'b1, 20, 2};
    vecs[7] = '{"eof_run",   10,  1, 16'h03C0, 16'h0000, 8'd200, 11'h400, 1'b1,  4, 1};

    reset_n = 1'b0; tv_x = '0; tv_y = '0; pix_valid = 1'b0; pix_luma = '0;
    mask = 11'h001; en = 1'b1; sof = 1'b0; eof = 1'b0; res_ready = 1'b0;
    step(); step();
    chk("rst.res_valid", {31'd0, res_valid}, 0);
    chk("rst.pix", {12'd0, res_pix_count}, 0);
    chk("rst.run", {16'd0, res_run_count}, 0);
    chk("rst.dropped", {24'd0, dropped}, 0);
    reset_n = 1'b1;
    step();

    // Table-driven frames: sof, lines of pixels, eof; result checked and then accepted.
    for (int i = 0; i < 8; i++) begin
      mask = vecs[i].mask;
      en   = vecs[i].en;
      px(1'b0, 0, 8'd0, 1'b1, 1'b0);
      for (int ln = 0; ln < vecs[i].nlines; ln++) begin
        logic [15:0] pat;
        pat  = (ln == 0) ? vecs[i].pat0 : vecs[i].pat1;
        tv_y = ln[9:0];
        for (int x = 0; x < vecs[i].width; x++)
          px(1'b1, x, pat[x] ? vecs[i].luma : 8'd0, 1'b0, 1'b0);
      end
      px(1'b0, 0, 8'd0, 1'b0, 1'b1);
      chk($sformatf("%0s.valid", vecs[i].name), {31'd0, res_valid}, 1);
      chk($sformatf("%0s.pix", vecs[i].name), {12'd0, res_pix_count}, vecs[i].exp_pix);
      chk($sformatf("%0s.run", vecs[i].name), {16'd0, res_run_count}, vecs[i].exp_run);
      accept();
      chk($sformatf("%0s.cleared", vecs[i].name), {31'd0, res_valid}, 0);
    end
    mask = 11'h001;
    en   = 1'b1;
    tv_y = '0;

    // Pixel on the sof cycle opens the frame; pixel on the eof cycle closes it.
    px(1'b1, 0, 8'd200, 1'b1, 1'b0);
    for (int x = 1; x < 5; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b1, 5, 8'd200, 1'b0, 1'b1);
    chk("sof_eof_px.pix", {12'd0, res_pix_count}, 6);
    chk("sof_eof_px.run", {16'd0, res_run_count}, 1);
    accept();

    // sof mid-frame aborts the partial frame without producing a result.
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int x = 0; x < 5; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    chk("abort.no_result", {31'd0, res_valid}, 0);
    px(1'b1, 0, 8'd200, 1'b0, 1'b0);
    px(1'b1, 1, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    chk("abort.pix", {12'd0, res_pix_count}, 2);
    chk("abort.run", {16'd0, res_run_count}, 0);
    accept();

    // sof and eof together: the frame completes and a new one starts empty.
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int x = 0; x < 4; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b1, 1'b1);
    chk("sofeof.valid", {31'd0, res_valid}, 1);
    chk("sofeof.pix", {12'd0, res_pix_count}, 4);
    chk("sofeof.run", {16'd0, res_run_count}, 1);
    accept();
    px(1'b1, 0, 8'd200, 1'b0, 1'b0);
    px(1'b1, 1, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    chk("sofeof.next_pix", {12'd0, res_pix_count}, 2);
    chk("sofeof.next_run", {16'd0, res_run_count}, 0);
    accept();

    // eof with no frame open is ignored.
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    step();
    chk("idle_eof.valid", {31'd0, res_valid}, 0);

    // Unaccepted result is overwritten by the next frame and counted as dropped.
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int x = 0; x < 6; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    step(); step(); step();
    chk("hold.valid", {31'd0, res_valid}, 1);
    chk("hold.pix", {12'd0, res_pix_count}, 6);
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int x = 0; x < 3; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    chk("ovw.valid", {31'd0, res_valid}, 1);
    chk("ovw.pix", {12'd0, res_pix_count}, 3);
    chk("ovw.run", {16'd0, res_run_count}, 0);
    chk("ovw.dropped", {24'd0, dropped}, 1);
    accept();
    chk("ovw.cleared", {31'd0, res_valid}, 0);
    chk("ovw.dropped_kept", {24'd0, dropped}, 1);

    // Reset mid-frame after 50 fg pixels discards everything asynchronously.
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int ln = 0; ln < 5; ln++)
      for (int x = 0; x < 10; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("arst.dropped", {24'd0, dropped}, 0);
    chk("arst.pix", {12'd0, res_pix_count}, 0);
    step();
    reset_n = 1'b1;
    step();
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    step();
    chk("arst.eof_no_sof", {31'd0, res_valid}, 0);
    for (int x = 0; x < 6; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b1, 1'b0);
    for (int x = 0; x < 5; x++) px(1'b1, x, 8'd200, 1'b0, 1'b0);
    px(1'b0, 0, 8'd0, 1'b0, 1'b1);
    chk("arst.valid", {31'd0, res_valid}, 1);
    chk("arst.pix5", {12'd0, res_pix_count}, 5);
    chk("arst.run1", {16'd0, res_run_count}, 1);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
